// File: rtl/dr_gray_encoder_pipe.sv
// dr_gray_encoder_pipe
// Four-phase dual-rail stage that converts a binary word (one bit per
// dual-rail channel) into its Gray code. Channel k occupies din[2k+1:2k],
// with [2k+1] the true rail and [2k] the false rail:
//   10 = 1, 01 = 0, 00 = NULL spacer, 11 = illegal.
// Handshake: IDLE accepts a complete word, HOLD presents the result until
// the downstream acknowledge, RTZ waits for both sides to return to zero.
// Every output is a flop; no input reaches an output combinationally.
// Optional macro DR_ILLEGAL_DETECT_EN builds a sticky illegal-code flag on
// err; without it err is tied low (an 11 code still blocks acceptance).
module dr_gray_encoder_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] din,
    input  logic               out_ack,
    output logic [2*WIDTH-1:0] dout,
    output logic               in_ack,
    output logic               busy,
    output logic [CNT_W-1:0]   tx_count,
    output logic               err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] RTZ  = 2'd2;

    logic [1:0] stateP1;

    // A word is complete when every channel is exactly one-hot (10 or 01),
    // which also rules out any 11 code.
    function automatic logic isComplete(input logic [2*WIDTH-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (d[2*k+1] == d[2*k]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic isAllNull(input logic [2*WIDTH-1:0] d);
        return (d == '0);
    endfunction

    // Binary-to-Gray on the true rails; shifting in a zero leaves the top
    // bit unchanged. Each Gray bit is re-expanded into a dual-rail code.
    function automatic logic [2*WIDTH-1:0] grayEncode(input logic [2*WIDTH-1:0] d);
        logic [WIDTH-1:0]   bin;
        logic [WIDTH-1:0]   gray;
        logic [2*WIDTH-1:0] rails;
        for (int k = 0; k < WIDTH; k++) begin
            bin[k] = d[2*k+1];
        end
        gray = bin ^ (bin >> 1);
        for (int k = 0; k < WIDTH; k++) begin
            rails[2*k+1] = gray[k];
            rails[2*k]   = ~gray[k];
        end
        return rails;
    endfunction

    // Handshake FSM with registered data, acknowledge, busy and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateP1  <= IDLE;
            dout     <= '0;
            in_ack   <= 1'b0;
            busy     <= 1'b0;
            tx_count <= '0;
        end else begin
            case (stateP1)
                IDLE: begin
                    if (isComplete(din)) begin
                        dout    <= grayEncode(din);
                        in_ack  <= 1'b1;
                        busy    <= 1'b1;
                        stateP1 <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        dout    <= '0;
                        stateP1 <= RTZ;
                    end
                end
                RTZ: begin
                    if (!out_ack && isAllNull(din)) begin
                        in_ack   <= 1'b0;
                        busy     <= 1'b0;
                        tx_count <= tx_count + CNT_W'(1);
                        stateP1  <= IDLE;
                    end
                end
                default: begin
                    dout    <= '0;
                    in_ack  <= 1'b0;
                    busy    <= 1'b0;
                    stateP1 <= IDLE;
                end
            endcase
        end
    end

`ifdef DR_ILLEGAL_DETECT_EN
    function automatic logic anyIllegal(input logic [2*WIDTH-1:0] d);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (d[2*k+1] && d[2*k]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Sticky flag: any 11 channel seen while IDLE latches err until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (stateP1 == IDLE && anyIllegal(din)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_gray_encoder_pipe.sv
// tb_dr_gray_encoder_pipe
// Directed bench: hand-computed Gray vectors, full handshakes with RTZ wait
// cases, partial/illegal input rejection, early acknowledge, counter wrap on
// a CNT_W=2 instance, and reset taken mid-handshake.
module tb_dr_gray_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       out_ack;

    logic [7:0] dout;
    logic       in_ack;
    logic       busy;
    logic [7:0] tx_count;
    logic       err;

    logic [7:0] doutS;
    logic       inAckS;
    logic       busyS;
    logic [1:0] txCountS;
    logic       errS;

    int nChecks = 0;
    int nFails  = 0;
    int expCnt  = 0;
    logic expErr = 1'b0;

`ifdef DR_ILLEGAL_DETECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dr_gray_encoder_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .out_ack(out_ack),
        .dout(dout), .in_ack(in_ack), .busy(busy), .tx_count(tx_count), .err(err)
    );

    dr_gray_encoder_pipe #(.WIDTH(4), .CNT_W(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .din(din), .out_ack(out_ack),
        .dout(doutS), .in_ack(inAckS), .busy(busyS), .tx_count(txCountS), .err(errS)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "_dout"}, 32'(dout), 32'h0);
        checkVal({tag, "_ack"},  32'(in_ack), 32'h0);
        checkVal({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Full handshake including din change in HOLD and both single-condition RTZ waits.
    task automatic doTx(input logic [7:0] v, input logic [7:0] g);
        din = v;
        tick();
        checkVal("cap_dout", 32'(dout), 32'(g));
        checkVal("cap_ack",  32'(in_ack), 32'h1);
        checkVal("cap_busy", 32'(busy), 32'h1);
        din = 8'b10_00_10_10;
        tick();
        checkVal("hold_dout", 32'(dout), 32'(g));
        checkVal("hold_ack",  32'(in_ack), 32'h1);
        out_ack = 1'b1;
        tick();
        checkVal("rtz_dout", 32'(dout), 32'h0);
        checkVal("rtz_ack",  32'(in_ack), 32'h1);
        checkVal("rtz_busy", 32'(busy), 32'h1);
        out_ack = 1'b0;
        tick();
        checkVal("rtz_wait_din", 32'(in_ack), 32'h1);
        din = 8'h00;
        out_ack = 1'b1;
        tick();
        checkVal("rtz_wait_ack", 32'(in_ack), 32'h1);
        out_ack = 1'b0;
        tick();
        expCnt++;
        checkIdle("done");
        checkVal("txcnt",       32'(tx_count), 32'(expCnt % 256));
        checkVal("txcnt_small", 32'(txCountS), 32'(expCnt % 4));
        checkVal("err_hold",    32'(err), 32'(expErr));
    endtask

    initial begin
        rst_n   = 1'b0;
        din     = 8'h00;
        out_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checkIdle("reset");
        checkVal("reset_cnt", 32'(tx_count), 32'h0);
        checkVal("reset_err", 32'(err), 32'h0);

        // Partial word held for five cycles must never be accepted.
        din = 8'b10_00_10_10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkIdle("partial");
        end

        // Illegal code: blocked, and flagged only when detection is built.
        din = 8'b11_01_01_01;
        tick();
        expErr = ERR_EN;
        checkIdle("illegal");
        checkVal("illegal_err", 32'(err), 32'(expErr));
        din = 8'h00;
        tick();

        // Five transactions: binary in, Gray out; small counter reads 1,2,3,0,1.
        doTx(8'b10_01_10_10, 8'b10_10_10_01);   // 1011 -> 1110
        doTx(8'b01_01_01_01, 8'b01_01_01_01);   // 0000 -> 0000
        doTx(8'b10_10_10_10, 8'b10_01_01_01);   // 1111 -> 1000
        doTx(8'b01_10_01_10, 8'b01_10_10_10);   // 0101 -> 0111
        doTx(8'b10_01_01_01, 8'b10_10_01_01);   // 1000 -> 1100

        // Acknowledge already high on entry to HOLD: HOLD lasts one cycle.
        out_ack = 1'b1;
        din = 8'b01_10_10_01;                   // 0110 -> 0101
        tick();
        checkVal("early_dout", 32'(dout), 32'(8'b01_10_01_10));
        checkVal("early_ack",  32'(in_ack), 32'h1);
        tick();
        checkVal("early_rtz_dout", 32'(dout), 32'h0);
        checkVal("early_rtz_ack",  32'(in_ack), 32'h1);
        din = 8'h00;
        out_ack = 1'b0;
        tick();
        expCnt++;
        checkIdle("early_done");
        checkVal("early_cnt", 32'(tx_count), 32'(expCnt % 256));

        // Reset asserted mid-handshake in HOLD.
        din = 8'b10_01_10_10;
        tick();
        checkVal("prerst_ack", 32'(in_ack), 32'h1);
        rst_n = 1'b0;
        tick();
        checkIdle("hold_reset");
        checkVal("hold_reset_cnt",   32'(tx_count), 32'h0);
        checkVal("hold_reset_cnt_s", 32'(txCountS), 32'h0);
        checkVal("hold_reset_err",   32'(err), 32'h0);
        rst_n = 1'b1;
        din = 8'h00;
        tick();
        checkIdle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
